// File: rtl/sync_gen_pkg.sv
// ============================================================================
// Module      : sync_gen_pkg
// Description : Region encoding, boundary computation and length legality
//               check shared by the sync timing generator files.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_gen_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } region_t;

    typedef struct packed {
        logic [31:0] front_start;
        logic [31:0] sync_start;
        logic [31:0] back_start;
        logic [31:0] total;
    } bounds_t;

    function automatic bounds_t calc_bounds(input logic [31:0] a,
                                            input logic [31:0] f,
                                            input logic [31:0] s,
                                            input logic [31:0] b);
        bounds_t r;
        r.front_start = a;
        r.sync_start  = a + f;
        r.back_start  = a + f + s;
        r.total       = a + f + s + b;
        return r;
    endfunction

    // Active and sync must be non-empty and the period must fit the counter.
    function automatic logic cfg_legal(input logic [31:0] a,
                                       input logic [31:0] f,
                                       input logic [31:0] s,
                                       input logic [31:0] b,
                                       input int unsigned width);
        logic [33:0] sum;
        sum = {2'b00, a} + {2'b00, f} + {2'b00, s} + {2'b00, b};
        return (a != 32'd0) && (s != 32'd0) && (sum <= (34'd1 << width));
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_region_fsm.sv
// ============================================================================
// Module      : sync_region_fsm
// Description : Next-region logic; advances through ACTIVE/FRONT/SYNC/BACK as
//               the next counter value crosses each boundary.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_region_fsm
    import sync_gen_pkg::*;
#(
    parameter int COUNTER_SIZE = 11
) (
    input  logic                  step,
    input  region_t               region_cur,
    input  logic [COUNTER_SIZE-1:0] count_nxt,
    input  logic [COUNTER_SIZE:0] front_start,
    input  logic [COUNTER_SIZE:0] sync_start,
    input  logic [COUNTER_SIZE:0] back_start,
    output region_t               region_nxt
);

    logic [COUNTER_SIZE:0] w_cnt;
    assign w_cnt = {1'b0, count_nxt};

    // Empty porches collapse boundaries: front==sync skips FRONT, and a
    // back_start equal to the period length is never reached so SYNC exits
    // straight to ACTIVE on the wrap.
    always_comb begin
        region_nxt = region_cur;
        if (step) begin
            if (w_cnt == '0) begin
                region_nxt = ACTIVE;
            end else begin
                case (region_cur)
                    ACTIVE: if (w_cnt == front_start)
                                region_nxt = (sync_start == front_start) ? SYNC : FRONT;
                    FRONT:  if (w_cnt == sync_start) region_nxt = SYNC;
                    SYNC:   if (w_cnt == back_start) region_nxt = BACK;
                    BACK:   region_nxt = BACK;
                    default: region_nxt = ACTIVE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sync_timing_generator.sv
// ============================================================================
// Module      : sync_timing_generator
// Description : One video timing axis: position counter, region FSM and
//               registered sync/blank/region/wrap outputs. Define
//               SYNC_GEN_RUNTIME_CFG_EN for runtime-loadable lengths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_timing_generator
    import sync_gen_pkg::*;
#(
    parameter int COUNTER_SIZE     = 11,
    parameter int ACTIVE_LEN       = 1024,
    parameter int FRONT_LEN        = 24,
    parameter int SYNC_LEN         = 136,
    parameter int BACK_LEN         = 160,
    parameter int SYNC_ACTIVE_HIGH = 0
) (
    input  logic                    control_clock,
    input  logic                    reset,
    input  logic                    step,
`ifdef SYNC_GEN_RUNTIME_CFG_EN
    input  logic [COUNTER_SIZE-1:0] cfg_active,
    input  logic [COUNTER_SIZE-1:0] cfg_front,
    input  logic [COUNTER_SIZE-1:0] cfg_sync,
    input  logic [COUNTER_SIZE-1:0] cfg_back,
    input  logic                    cfg_load,
`endif
    output logic [COUNTER_SIZE-1:0] counter_out,
    output logic                    sync,
    output logic                    blank,
    output logic [1:0]              region,
    output logic                    wrap
);

    localparam logic [COUNTER_SIZE-1:0] C_LEN_A   = COUNTER_SIZE'(ACTIVE_LEN);
    localparam logic [COUNTER_SIZE-1:0] C_LEN_F   = COUNTER_SIZE'(FRONT_LEN);
    localparam logic [COUNTER_SIZE-1:0] C_LEN_S   = COUNTER_SIZE'(SYNC_LEN);
    localparam logic [COUNTER_SIZE-1:0] C_LEN_B   = COUNTER_SIZE'(BACK_LEN);
    localparam logic                    C_SYNC_ON = (SYNC_ACTIVE_HIGH != 0);

    generate
        if (!cfg_legal(32'(ACTIVE_LEN), 32'(FRONT_LEN), 32'(SYNC_LEN),
                       32'(BACK_LEN), COUNTER_SIZE)) begin : g_bad_params
            $error("sync_timing_generator: illegal length parameters");
        end
    endgenerate

    logic [COUNTER_SIZE-1:0] w_len_a, w_len_f, w_len_s, w_len_b;
    logic                    w_last;

`ifdef SYNC_GEN_RUNTIME_CFG_EN
    logic [COUNTER_SIZE-1:0] r_live_a, r_live_f, r_live_s, r_live_b;
    logic [COUNTER_SIZE-1:0] r_pend_a, r_pend_f, r_pend_s, r_pend_b;
    logic                    w_cfg_ok;

    assign w_cfg_ok = cfg_legal(32'(cfg_active), 32'(cfg_front), 32'(cfg_sync),
                                32'(cfg_back), COUNTER_SIZE);

    // Pending lengths only go live on the wrap edge so a period never changes shape.
    always_ff @(posedge control_clock) begin
        if (reset) begin
            r_live_a <= C_LEN_A;
            r_live_f <= C_LEN_F;
            r_live_s <= C_LEN_S;
            r_live_b <= C_LEN_B;
            r_pend_a <= C_LEN_A;
            r_pend_f <= C_LEN_F;
            r_pend_s <= C_LEN_S;
            r_pend_b <= C_LEN_B;
        end else begin
            if (cfg_load && w_cfg_ok) begin
                r_pend_a <= cfg_active;
                r_pend_f <= cfg_front;
                r_pend_s <= cfg_sync;
                r_pend_b <= cfg_back;
            end
            if (step && w_last) begin
                r_live_a <= r_pend_a;
                r_live_f <= r_pend_f;
                r_live_s <= r_pend_s;
                r_live_b <= r_pend_b;
            end
        end
    end

    assign w_len_a = r_live_a;
    assign w_len_f = r_live_f;
    assign w_len_s = r_live_s;
    assign w_len_b = r_live_b;
`else
    assign w_len_a = C_LEN_A;
    assign w_len_f = C_LEN_F;
    assign w_len_s = C_LEN_S;
    assign w_len_b = C_LEN_B;
`endif

    bounds_t                 w_bounds;
    logic [COUNTER_SIZE:0]   w_front_start, w_sync_start, w_back_start, w_total;
    logic [COUNTER_SIZE-1:0] r_count, w_count_nxt;
    region_t                 r_region, w_region_nxt;
    logic                    r_sync, r_blank, r_wrap;

    assign w_bounds      = calc_bounds(32'(w_len_a), 32'(w_len_f), 32'(w_len_s), 32'(w_len_b));
    assign w_front_start = (COUNTER_SIZE+1)'(w_bounds.front_start);
    assign w_sync_start  = (COUNTER_SIZE+1)'(w_bounds.sync_start);
    assign w_back_start  = (COUNTER_SIZE+1)'(w_bounds.back_start);
    assign w_total       = (COUNTER_SIZE+1)'(w_bounds.total);

    assign w_last      = ({1'b0, r_count} == (w_total - 1'b1));
    assign w_count_nxt = step ? (w_last ? '0 : r_count + 1'b1) : r_count;

    sync_region_fsm #(
        .COUNTER_SIZE (COUNTER_SIZE)
    ) u_region_fsm (
        .step        (step),
        .region_cur  (r_region),
        .count_nxt   (w_count_nxt),
        .front_start (w_front_start),
        .sync_start  (w_sync_start),
        .back_start  (w_back_start),
        .region_nxt  (w_region_nxt)
    );

    // All outputs derive from the next position so they change together.
    always_ff @(posedge control_clock) begin
        if (reset) begin
            r_count  <= '0;
            r_region <= ACTIVE;
            r_sync   <= ~C_SYNC_ON;
            r_blank  <= 1'b0;
            r_wrap   <= 1'b0;
        end else begin
            r_count  <= w_count_nxt;
            r_region <= w_region_nxt;
            r_sync   <= (w_region_nxt == SYNC) ? C_SYNC_ON : ~C_SYNC_ON;
            r_blank  <= (w_region_nxt != ACTIVE);
            r_wrap   <= step && w_last;
        end
    end

    assign counter_out = r_count;
    assign region      = r_region;
    assign sync        = r_sync;
    assign blank       = r_blank;
    assign wrap        = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_sync_timing_generator.sv
// ============================================================================
// Module      : tb_sync_timing_generator
// Description : Directed table-driven bench for sync_timing_generator; covers
//               runtime config when SYNC_GEN_RUNTIME_CFG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_timing_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, stp;
    logic [3:0] cnt0, cnt1, cnt2;
    logic [1:0] reg0, reg1, reg2;
    logic       snc0, snc1, snc2, blk0, blk1, blk2, wrp0, wrp1, wrp2;
`ifdef SYNC_GEN_RUNTIME_CFG_EN
    logic [3:0] cfg_a, cfg_f, cfg_s, cfg_b;
    logic       cfg_ld;
`endif

    sync_timing_generator #(.COUNTER_SIZE(4), .ACTIVE_LEN(4), .FRONT_LEN(1),
                            .SYNC_LEN(2), .BACK_LEN(1), .SYNC_ACTIVE_HIGH(0)) dut0 (
        .control_clock(clk), .reset(rst), .step(stp),
`ifdef SYNC_GEN_RUNTIME_CFG_EN
        .cfg_active(cfg_a), .cfg_front(cfg_f), .cfg_sync(cfg_s), .cfg_back(cfg_b),
        .cfg_load(cfg_ld),
`endif
        .counter_out(cnt0), .sync(snc0), .blank(blk0), .region(reg0), .wrap(wrp0));

    sync_timing_generator #(.COUNTER_SIZE(4), .ACTIVE_LEN(4), .FRONT_LEN(0),
                            .SYNC_LEN(2), .BACK_LEN(0), .SYNC_ACTIVE_HIGH(0)) dut1 (
        .control_clock(clk), .reset(rst), .step(stp),
`ifdef SYNC_GEN_RUNTIME_CFG_EN
        .cfg_active(4'd0), .cfg_front(4'd0), .cfg_sync(4'd0), .cfg_back(4'd0),
        .cfg_load(1'b0),
`endif
        .counter_out(cnt1), .sync(snc1), .blank(blk1), .region(reg1), .wrap(wrp1));

    sync_timing_generator #(.COUNTER_SIZE(4), .ACTIVE_LEN(4), .FRONT_LEN(1),
                            .SYNC_LEN(2), .BACK_LEN(1), .SYNC_ACTIVE_HIGH(1)) dut2 (
        .control_clock(clk), .reset(rst), .step(stp),
`ifdef SYNC_GEN_RUNTIME_CFG_EN
        .cfg_active(4'd0), .cfg_front(4'd0), .cfg_sync(4'd0), .cfg_back(4'd0),
        .cfg_load(1'b0),
`endif
        .counter_out(cnt2), .sync(snc2), .blank(blk2), .region(reg2), .wrap(wrp2));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int region_of(input int c, input int a, input int f, input int s);
        if (c < a)         return 0;
        if (c < a + f)     return 1;
        if (c < a + f + s) return 2;
        return 3;
    endfunction

    typedef struct {
        logic r;
        logic s;
        int   cnt;
        int   rg;
        int   sn;
        int   bl;
        int   wr;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int m1, p1, e1, k;
        int exp_seq[14];

        rst = 1'b1;
        stp = 1'b0;
`ifdef SYNC_GEN_RUNTIME_CFG_EN
        cfg_a = 4'd0; cfg_f = 4'd0; cfg_s = 4'd0; cfg_b = 4'd0; cfg_ld = 1'b0;
`endif

        // {reset, step, count, region, sync, blank, wrap} for dut0 (A4 F1 S2 B1)
        tbl.push_back('{1, 0, 0, 0, 1, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 1, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 1, 0, 0});
        tbl.push_back('{0, 1, 2, 0, 1, 0, 0});
        tbl.push_back('{0, 1, 3, 0, 1, 0, 0});
        tbl.push_back('{0, 1, 4, 1, 1, 1, 0});
        tbl.push_back('{0, 1, 5, 2, 0, 1, 0});
        tbl.push_back('{0, 1, 6, 2, 0, 1, 0});
        tbl.push_back('{0, 1, 7, 3, 1, 1, 0});
        tbl.push_back('{0, 1, 0, 0, 1, 0, 1});
        tbl.push_back('{0, 1, 1, 0, 1, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 1, 0, 0});
        tbl.push_back('{0, 1, 2, 0, 1, 0, 0});
        tbl.push_back('{0, 1, 3, 0, 1, 0, 0});
        tbl.push_back('{0, 1, 4, 1, 1, 1, 0});
        tbl.push_back('{0, 1, 5, 2, 0, 1, 0});
        tbl.push_back('{1, 1, 0, 0, 1, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 1, 0, 0});

        m1 = 0;
        foreach (tbl[i]) begin
            rst = tbl[i].r;
            stp = tbl[i].s;
            @(posedge clk); #1;
            p1 = m1;
            if (tbl[i].r) m1 = 0;
            else if (tbl[i].s) m1 = (m1 + 1) % 6;
            e1 = region_of(m1, 4, 0, 2);
            chk($sformatf("v%0d cnt0", i), cnt0, tbl[i].cnt);
            chk($sformatf("v%0d reg0", i), reg0, tbl[i].rg);
            chk($sformatf("v%0d sync0", i), snc0, tbl[i].sn);
            chk($sformatf("v%0d blank0", i), blk0, tbl[i].bl);
            chk($sformatf("v%0d wrap0", i), wrp0, tbl[i].wr);
            chk($sformatf("v%0d cnt1", i), cnt1, m1);
            chk($sformatf("v%0d reg1", i), reg1, e1);
            chk($sformatf("v%0d sync1", i), snc1, (e1 == 2) ? 0 : 1);
            chk($sformatf("v%0d wrap1", i), wrp1,
                (!tbl[i].r && tbl[i].s && p1 == 5) ? 1 : 0);
            chk($sformatf("v%0d cnt2", i), cnt2, tbl[i].cnt);
            chk($sformatf("v%0d sync2", i), snc2, 1 - tbl[i].sn);
        end

        // Sparse stepping: one step every third cycle, outputs frozen between.
        rst = 1'b1; stp = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int s = 1; s <= 8; s++) begin
            k = s % 8;
            stp = 1'b1;
            @(posedge clk); #1;
            stp = 1'b0;
            chk($sformatf("sparse%0d cnt", s), cnt0, k);
            chk($sformatf("sparse%0d reg", s), reg0, region_of(k, 4, 1, 2));
            chk($sformatf("sparse%0d wrap", s), wrp0, (s == 8) ? 1 : 0);
            for (int h = 0; h < 2; h++) begin
                @(posedge clk); #1;
                chk($sformatf("sparse%0d hold%0d cnt", s, h), cnt0, k);
                chk($sformatf("sparse%0d hold%0d wrap", s, h), wrp0, 0);
            end
        end

`ifdef SYNC_GEN_RUNTIME_CFG_EN
        // Load {2,1,1,1} mid-period: current period stays 8, then 5 per period.
        rst = 1'b1; stp = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; stp = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("cfg pre cnt", cnt0, 3);
        cfg_a = 4'd2; cfg_f = 4'd1; cfg_s = 4'd1; cfg_b = 4'd1; cfg_ld = 1'b1;
        @(posedge clk); #1;
        cfg_ld = 1'b0;
        chk("cfg load cnt", cnt0, 4);
        exp_seq = '{5, 6, 7, 0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            cfg_ld = 1'b0;
            chk($sformatf("cfg%0d cnt", i), cnt0, exp_seq[i]);
            chk($sformatf("cfg%0d wrap", i), wrp0, (exp_seq[i] == 0) ? 1 : 0);
            e1 = (i < 3) ? region_of(exp_seq[i], 4, 1, 2) : region_of(exp_seq[i], 2, 1, 1);
            chk($sformatf("cfg%0d reg", i), reg0, e1);
            chk($sformatf("cfg%0d sync", i), snc0, (e1 == 2) ? 0 : 1);
            if (i == 4) begin
                cfg_a = 4'd0; cfg_f = 4'd1; cfg_s = 4'd1; cfg_b = 4'd1; cfg_ld = 1'b1;
            end
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
